// File: rtl/stage_3_carry_pkg.sv
// stage_3_carry_pkg: shared widths, constants and state encoding for the carry-resolution stage
package stage_3_carry_pkg;
    localparam int BYTE_WIDTH = 8;
    localparam int RUN_WIDTH  = 8;
    localparam int PC_WIDTH   = BYTE_WIDTH + 1;
    localparam int CARRY_BIT  = BYTE_WIDTH;
    localparam int BYTE_MSB   = BYTE_WIDTH - 1;
    localparam logic [BYTE_WIDTH-1:0] BYTE_FF     = 8'hFF;
    localparam logic [PC_WIDTH-1:0]   PRECARRY_FF = 9'h0FF;
    localparam logic [RUN_WIDTH-1:0]  RUN_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        EMIT_HELD,
        EMIT_RUN,
        FLUSH_HELD,
        FLUSH_RUN
    } state_e;

    // A carry turns every pending 0xFF into 0x00
    function automatic logic [BYTE_WIDTH-1:0] run_byte(input logic c);
        return c ? '0 : BYTE_FF;
    endfunction
endpackage

// File: rtl/stage_3_carry_if.sv
// stage_3_carry_if: pre-carry input, byte output and status signals of the carry stage
interface stage_3_carry_if;
    import stage_3_carry_pkg::*;
    logic                  in_valid;
    logic                  in_ready;
    logic [PC_WIDTH-1:0]   in_precarry;
    logic                  in_flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [BYTE_WIDTH-1:0] out_byte;
    logic                  out_last;
    logic                  flush_done;
    logic                  run_overflow;

    modport master (
        output in_valid, in_precarry, in_flush, out_ready,
        input  in_ready, out_valid, out_byte, out_last, flush_done, run_overflow
    );
    modport slave (
        input  in_valid, in_precarry, in_flush, out_ready,
        output in_ready, out_valid, out_byte, out_last, flush_done, run_overflow
    );
endinterface

// File: rtl/stage_3_carry_out_byte_reg.sv
// stage_3_carry_out_byte_reg: single-entry valid/ready output register, stable while stalled
module stage_3_carry_out_byte_reg
    import stage_3_carry_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [BYTE_WIDTH-1:0] byte_o,
    output logic                  last_o
);
    logic                  valid_q;
    logic [BYTE_WIDTH-1:0] byte_q;
    logic                  last_q;

    // The owner only loads when empty or while the current byte is being taken
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            byte_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            byte_q  <= byte_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign byte_o  = byte_q;
    assign last_o  = last_q;
endmodule

// File: rtl/stage_3_carry.sv
// stage_3_carry: resolves carries into the held byte and pending 0xFF run, emits final bytes
module stage_3_carry
    import stage_3_carry_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    stage_3_carry_if.slave bus
);
    state_e                state_q;
    logic [BYTE_WIDTH-1:0] held_q;
    logic [RUN_WIDTH-1:0]  run_q;
    logic                  carry_q;
    logic                  flush_pend_q;
    logic                  flush_done_q;
    logic                  overflow_q;

    logic                  in_ready, acc, flush_acc, is_ff, in_c, hs;
    logic                  emitting, flushing, start_flush, emit_new, more;
    logic                  load_d, last_d;
    logic [BYTE_WIDTH-1:0] byte_d;

    always_comb begin
        in_ready    = !reset && (state_q == IDLE || state_q == HOLD) && !flush_pend_q;
        acc         = bus.in_valid && in_ready;
        flush_acc   = bus.in_flush && in_ready;
        is_ff       = bus.in_precarry == PRECARRY_FF;
        in_c        = bus.in_precarry[CARRY_BIT];
        hs          = bus.out_valid && bus.out_ready;
        emitting    = state_q == EMIT_HELD || state_q == EMIT_RUN;
        flushing    = state_q == FLUSH_HELD || state_q == FLUSH_RUN;
        start_flush = state_q == HOLD && (flush_pend_q || (flush_acc && !bus.in_valid));
        emit_new    = state_q == HOLD && acc && !is_ff;
        more        = hs && (emitting || flushing) && run_q != '0;
        load_d      = start_flush || emit_new || more;
        byte_d      = start_flush ? held_q :
                      emit_new    ? held_q + BYTE_WIDTH'(in_c) :
                      flushing    ? BYTE_FF : run_byte(carry_q);
        last_d      = start_flush ? (run_q == '0) : (flushing && run_q == RUN_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            held_q       <= '0;
            run_q        <= '0;
            carry_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (emit_new)
                assert (!(in_c && held_q == BYTE_FF));
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        held_q       <= bus.in_precarry[BYTE_MSB:0];
                        flush_pend_q <= bus.in_flush;
                        state_q      <= HOLD;
                    end else if (flush_acc) begin
                        flush_done_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (start_flush) begin
                        flush_pend_q <= 1'b0;
                        state_q      <= FLUSH_HELD;
                    end else if (acc && is_ff) begin
                        run_q        <= (run_q == RUN_MAX) ? run_q : run_q + RUN_WIDTH'(1);
                        overflow_q   <= overflow_q || run_q == RUN_MAX;
                        flush_pend_q <= bus.in_flush;
                    end else if (acc) begin
                        carry_q      <= in_c;
                        held_q       <= bus.in_precarry[BYTE_MSB:0];
                        flush_pend_q <= bus.in_flush;
                        state_q      <= EMIT_HELD;
                    end
                end
                EMIT_HELD, EMIT_RUN: begin
                    if (hs) begin
                        run_q   <= (run_q != '0) ? run_q - RUN_WIDTH'(1) : run_q;
                        state_q <= (run_q != '0) ? EMIT_RUN : HOLD;
                    end
                end
                FLUSH_HELD, FLUSH_RUN: begin
                    if (hs && run_q != '0) begin
                        run_q   <= run_q - RUN_WIDTH'(1);
                        state_q <= FLUSH_RUN;
                    end else if (hs) begin
                        held_q       <= '0;
                        flush_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    stage_3_carry_out_byte_reg u_out (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_d),
        .byte_i (byte_d),
        .last_i (last_d),
        .ready_i(bus.out_ready),
        .valid_o(bus.out_valid),
        .byte_o (bus.out_byte),
        .last_o (bus.out_last)
    );

    assign bus.in_ready     = in_ready;
    assign bus.flush_done   = flush_done_q;
    assign bus.run_overflow = overflow_q;
endmodule

// File: tb/tb_stage_3_carry.sv
// tb_stage_3_carry: directed and randomized checks of stage_3_carry against a byte-stream model
module tb_stage_3_carry;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stage_3_carry_if bus ();
    stage_3_carry dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: the stream is held byte followed by run 0xFF bytes; a carry adds one to that number
    logic [8:0] m_q[$];
    logic [8:0] out_log[$];
    logic [7:0] m_held = 8'h00;
    bit         m_hv = 0;
    int         m_run = 0;
    bit         m_ov = 0;
    bit         exp_fd = 0;
    int         fd_cnt = 0;
    bit         p_stall = 0;
    logic [7:0] p_byte = 8'h00;
    logic       p_last = 1'b0;

    task automatic model_byte(input logic [8:0] b);
        logic [7:0] s;
        if (!m_hv) begin
            m_held = b[7:0];
            m_hv = 1;
        end else if (b == 9'h0FF) begin
            if (m_run == 255) m_ov = 1;
            else m_run++;
        end else begin
            s = m_held + 8'(b[8]);
            m_q.push_back({1'b0, s});
            for (int i = 0; i < m_run; i++) m_q.push_back({1'b0, b[8] ? 8'h00 : 8'hFF});
            m_run = 0;
            m_held = b[7:0];
        end
    endtask

    task automatic model_flush(output bit fd_now);
        fd_now = !m_hv;
        if (m_hv) begin
            m_q.push_back({m_run == 0, m_held});
            for (int i = 0; i < m_run; i++) m_q.push_back({i == m_run - 1, 8'hFF});
            m_run = 0;
            m_hv = 0;
        end
    endtask

    always @(negedge clk) begin : monitor
        bit nfd;
        bit fdf;
        logic [8:0] e;
        if (reset) begin
            m_q.delete();
            m_hv = 0;
            m_run = 0;
            m_ov = 0;
            exp_fd = 0;
            p_stall = 0;
        end else begin
            nfd = 0;
            chk("flush_done", 32'(bus.flush_done), 32'(exp_fd));
            chk("run_overflow", 32'(bus.run_overflow), 32'(m_ov));
            if (bus.flush_done) fd_cnt++;
            if (p_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_byte", 32'(bus.out_byte), 32'(p_byte));
                chk("stall_last", 32'(bus.out_last), 32'(p_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_log.push_back({bus.out_last, bus.out_byte});
                if (m_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", bus.out_byte);
                end else begin
                    e = m_q.pop_front();
                    chk("out_byte", 32'(bus.out_byte), 32'(e[7:0]));
                    chk("out_last", 32'(bus.out_last), 32'(e[8]));
                    nfd = e[8];
                end
            end
            if (bus.in_valid && bus.in_ready) model_byte(bus.in_precarry);
            if (bus.in_flush && bus.in_ready) begin
                model_flush(fdf);
                nfd = nfd | fdf;
            end
            exp_fd = nfd;
            p_stall = bus.out_valid && !bus.out_ready;
            p_byte = bus.out_byte;
            p_last = bus.out_last;
        end
    end

    bit rdy_rand = 0;
    bit rdy_val = 1;
    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic send(input logic v, input logic [8:0] b, input logic f);
        int n = 0;
        bus.in_valid = v;
        bus.in_precarry = b;
        bus.in_flush = f;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("in_ready_wait", 32'(bus.in_ready), 1);
        sync();
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (out_log.size() < n && k < 3000) begin
            k++;
            @(negedge clk);
        end
        chk("log_size", out_log.size(), n);
        sync();
    endtask

    task automatic chk_out_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_byte"}, 32'(bus.out_byte), 0);
        chk({tag, "_out_last"}, 32'(bus.out_last), 0);
        chk({tag, "_flush_done"}, 32'(bus.flush_done), 0);
        chk({tag, "_run_overflow"}, 32'(bus.run_overflow), 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int fd0;
        int k;
        int nff;
        logic [8:0] b;
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b0;
        bus.in_precarry = '0;
        repeat (3) @(negedge clk);
        chk_out_zero("reset");
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.in_ready), 1);
        sync();

        // Two bytes then flush
        fd0 = fd_cnt;
        out_log.delete();
        send(1, 9'h012, 0);
        send(1, 9'h034, 0);
        send(0, 9'h000, 1);
        wait_log(2);
        chk("t1_b0", 32'(out_log[0]), 32'h012);
        chk("t1_b1_last", 32'(out_log[1]), 32'h134);
        idle(3);
        chk("t1_flush_done_once", fd_cnt - fd0, 1);

        // Carry through a run of three 0xFF
        out_log.delete();
        send(1, 9'h040, 0);
        repeat (3) send(1, 9'h0FF, 0);
        send(1, 9'h105, 0);
        wait_log(4);
        chk("t2_b0", 32'(out_log[0]), 32'h041);
        chk("t2_b1", 32'(out_log[1]), 32'h000);
        chk("t2_b2", 32'(out_log[2]), 32'h000);
        chk("t2_b3", 32'(out_log[3]), 32'h000);
        send(0, 9'h000, 1);
        wait_log(5);
        chk("t2_held_after", 32'(out_log[4]), 32'h105);

        // No carry: run stays 0xFF, input blocked during the drain
        out_log.delete();
        send(1, 9'h040, 0);
        repeat (2) send(1, 9'h0FF, 0);
        send(1, 9'h005, 0);
        for (int i = 0; i < 50 && out_log.size() < 3; i++) begin
            @(negedge clk);
            if (out_log.size() < 3) chk("t3_ready_drain", 32'(bus.in_ready), 0);
        end
        wait_log(3);
        chk("t3_b0", 32'(out_log[0]), 32'h040);
        chk("t3_b1", 32'(out_log[1]), 32'h0FF);
        chk("t3_b2", 32'(out_log[2]), 32'h0FF);
        send(0, 9'h000, 1);
        wait_log(4);
        chk("t3_held_after", 32'(out_log[3]), 32'h105);

        // Downstream stall mid-run
        out_log.delete();
        send(1, 9'h040, 0);
        repeat (3) send(1, 9'h0FF, 0);
        send(1, 9'h005, 0);
        k = 0;
        while (out_log.size() < 1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        rdy_val = 0;
        repeat (3) @(negedge clk);
        chk("t4_stalled_valid", 32'(bus.out_valid), 1);
        chk("t4_stalled_ready", 32'(bus.out_ready), 0);
        repeat (3) @(negedge clk);
        rdy_val = 1;
        wait_log(4);
        chk("t4_b0", 32'(out_log[0]), 32'h040);
        chk("t4_b1", 32'(out_log[1]), 32'h0FF);
        chk("t4_b2", 32'(out_log[2]), 32'h0FF);
        chk("t4_b3", 32'(out_log[3]), 32'h0FF);
        send(0, 9'h000, 1);
        wait_log(5);
        chk("t4_held_after", 32'(out_log[4]), 32'h105);

        // Run counter saturation
        out_log.delete();
        send(1, 9'h011, 0);
        repeat (255) send(1, 9'h0FF, 0);
        @(negedge clk);
        chk("t5_ovf_at_255", 32'(bus.run_overflow), 0);
        sync();
        send(1, 9'h0FF, 0);
        @(negedge clk);
        chk("t5_ovf_at_256", 32'(bus.run_overflow), 1);
        sync();
        send(0, 9'h000, 1);
        wait_log(256);
        chk("t5_first", 32'(out_log[0]), 32'h011);
        nff = 0;
        for (int i = 1; i < 256; i++) if (out_log[i][7:0] == 8'hFF) nff++;
        chk("t5_ff_count", nff, 255);
        chk("t5_last_flag", 32'(out_log[255][8]), 1);
        chk("t5_not_last_early", 32'(out_log[254][8]), 0);
        @(negedge clk);
        chk("t5_ovf_sticky", 32'(bus.run_overflow), 1);
        sync();

        // Byte and flush in the same cycle
        out_log.delete();
        fd0 = fd_cnt;
        send(1, 9'h010, 0);
        send(1, 9'h120, 1);
        wait_log(2);
        chk("t6_b0", 32'(out_log[0]), 32'h011);
        chk("t6_b1_last", 32'(out_log[1]), 32'h120);
        idle(3);
        chk("t6_flush_done_once", fd_cnt - fd0, 1);

        // Reset while a drain is stalled
        out_log.delete();
        rdy_val = 0;
        idle(2);
        send(1, 9'h010, 0);
        repeat (3) send(1, 9'h0FF, 0);
        send(1, 9'h105, 0);
        idle(2);
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        chk_out_zero("t7_reset");
        sync();
        reset = 1'b0;
        rdy_val = 1;
        idle(10);
        @(negedge clk);
        chk("t7_no_bytes_after_reset", out_log.size(), 0);
        chk("t7_out_valid", 32'(bus.out_valid), 0);
        sync();

        // Randomized traffic with random backpressure
        rdy_rand = 1;
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 99);
            if (k < 5) begin
                send(0, 9'h000, 1);
            end else if (k < 8) begin
                idle($urandom_range(1, 3));
            end else begin
                b[7:0] = 8'($urandom_range(0, 254));
                b[8] = 1'($urandom_range(0, 1));
                if (m_hv && m_held == 8'hFF) b[8] = 1'b0;
                if ($urandom_range(0, 3) == 0) b = 9'h0FF;
                send(1, b, 1'($urandom_range(0, 19) == 0));
            end
        end
        send(0, 9'h000, 1);
        k = 0;
        while ((m_q.size() != 0 || bus.out_valid) && k < 3000) begin
            k++;
            @(negedge clk);
        end
        idle(3);
        chk("final_drain", m_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
